// File: rtl/puf_challenge_sequencer_if.sv
// Key delivery channel from the PUF challenge sequencer to key storage.
// valid/ready: a key transfers on an edge where key_valid && key_ready; key_out is stable while key_valid is high.
interface puf_challenge_sequencer_if #(
   parameter int KEY_W = 64
) ();
   logic [KEY_W-1:0] key_out;
   logic             key_valid;
   logic             key_ready;

   modport master (
      output key_out,
      output key_valid,
      input  key_ready
   );

   modport slave (
      input  key_out,
      input  key_valid,
      output key_ready
   );
endinterface

// File: rtl/puf_challenge_sequencer.sv
// Steps an RO PUF through a list of challenge select pairs, samples the synchronised
// 4-bit response after each evaluation window and packs the results into one key word.
module puf_challenge_sequencer #(
   parameter int NUM_CHALLENGES = 16,
   parameter int SETTLE_CYCLES  = 4,
   parameter int EVAL_CYCLES    = 1024,
   parameter int CNT_W          = 16
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       start,
   input  logic [3:0]                 sel_offset,
   input  logic [3:0]                 puf_response,
   output logic                       puf_reset,
   output logic [3:0]                 sel0,
   output logic [3:0]                 sel1,
   output logic                       busy,
   output logic [2:0]                 dbg_state,
   puf_challenge_sequencer_if.master  key_if
);

   localparam int KEY_W = 4 * NUM_CHALLENGES;
   localparam int IDX_W = (NUM_CHALLENGES > 1) ? $clog2(NUM_CHALLENGES) : 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETTLE = 3'd1,
      S_EVAL   = 3'd2,
      S_SAMPLE = 3'd3,
      S_DONE   = 3'd4
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [3:0]       off_q, off_d;
   logic [3:0]       sel0_q, sel0_d;
   logic [3:0]       sel1_q, sel1_d;
   logic [3:0]       sync1_q, sync1_d;
   logic [3:0]       sync2_q, sync2_d;
   logic [KEY_W-1:0] key_q, key_d;
   logic             puf_reset_q, puf_reset_d;
   logic             busy_q, busy_d;
   logic             valid_q, valid_d;
   logic [3:0]       next_sel0;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         off_q       <= 4'd1;
         sel0_q      <= 4'd0;
         sel1_q      <= 4'd0;
         sync1_q     <= 4'd0;
         sync2_q     <= 4'd0;
         key_q       <= '0;
         puf_reset_q <= 1'b1;
         busy_q      <= 1'b0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         off_q       <= off_d;
         sel0_q      <= sel0_d;
         sel1_q      <= sel1_d;
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         key_q       <= key_d;
         puf_reset_q <= puf_reset_d;
         busy_q      <= busy_d;
         valid_q     <= valid_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      off_d     = off_q;
      sel0_d    = sel0_q;
      sel1_d    = sel1_q;
      key_d     = key_q;
      sync1_d   = puf_response;
      sync2_d   = sync1_q;
      // Selects wrap on the low nibble of the challenge index.
      next_sel0 = 4'(idx_q) + 4'd1;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_SETTLE;
               cnt_d   = '0;
               idx_d   = '0;
               key_d   = '0;
               off_d   = (sel_offset == 4'd0) ? 4'd1 : sel_offset;
               sel0_d  = 4'd0;
               sel1_d  = off_d;
            end
         end
         S_SETTLE: begin
            if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
               state_d = S_EVAL;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_EVAL: begin
            if (cnt_q == CNT_W'(EVAL_CYCLES - 1)) begin
               state_d = S_SAMPLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_SAMPLE: begin
            key_d[4*idx_q +: 4] = sync2_q;
            cnt_d               = '0;
            if (idx_q == IDX_W'(NUM_CHALLENGES - 1)) begin
               state_d = S_DONE;
            end else begin
               state_d = S_SETTLE;
               idx_d   = idx_q + 1'b1;
               sel0_d  = next_sel0;
               sel1_d  = next_sel0 + off_q;
            end
         end
         S_DONE: begin
            if (valid_q && key_if.key_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered from the next state so they line up with state_q.
      puf_reset_d = !((state_d == S_EVAL) || (state_d == S_SAMPLE));
      busy_d      = (state_d == S_SETTLE) || (state_d == S_EVAL) || (state_d == S_SAMPLE);
      valid_d     = (state_d == S_DONE);
   end

   assign puf_reset        = puf_reset_q;
   assign sel0             = sel0_q;
   assign sel1             = sel1_q;
   assign busy             = busy_q;
   assign dbg_state        = state_q;
   assign key_if.key_out   = key_q;
   assign key_if.key_valid = valid_q;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Bench for puf_challenge_sequencer: table of key runs plus hand-built window, backpressure and abort sequences.
module tb_puf_challenge_sequencer;
   localparam int NC      = 4;
   localparam int SC      = 2;
   localparam int EC      = 8;
   localparam int KW      = 4 * NC;
   localparam int PER     = SC + EC + 1;
   localparam int KEY_LAT = 1 + NC * PER;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start;
   logic [3:0]    sel_offset;
   logic [3:0]    puf_response;
   logic          puf_reset;
   logic [3:0]    sel0;
   logic [3:0]    sel1;
   logic          busy;
   logic [2:0]    dbg_state;
   logic          ovr;
   logic [3:0]    man;

   int total = 0;
   int bad   = 0;
   logic [KW-1:0] exp_q[$];

   typedef struct {
      logic [3:0]    off;
      int            ready_delay;
      logic [KW-1:0] exp_key;
   } vec_t;
   vec_t vecs[4];

   puf_challenge_sequencer_if #(.KEY_W(KW)) key_if ();

   puf_challenge_sequencer #(
      .NUM_CHALLENGES (NC),
      .SETTLE_CYCLES  (SC),
      .EVAL_CYCLES    (EC),
      .CNT_W          (16)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .sel_offset   (sel_offset),
      .puf_response (puf_response),
      .puf_reset    (puf_reset),
      .sel0         (sel0),
      .sel1         (sel1),
      .busy         (busy),
      .dbg_state    (dbg_state),
      .key_if       (key_if)
   );

   // PUF model: response is the XOR of the two selects unless overridden.
   assign puf_response = ovr ? man : (sel0 ^ sel1);

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_puf_reset"}, 32'(puf_reset), 32'd1);
      chk({tag, "_sel0"}, 32'(sel0), 32'd0);
      chk({tag, "_sel1"}, 32'(sel1), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_key_valid"}, 32'(key_if.key_valid), 32'd0);
      chk({tag, "_key_out"}, 32'(key_if.key_out), 32'd0);
      chk({tag, "_state"}, 32'(dbg_state), 32'd0);
   endtask

   // One key generation. Response overrides change at negedges n1/n2; abort_n > 0 asserts reset there.
   task automatic run_key(input logic [3:0] off, input int ready_delay, input logic [KW-1:0] exp_key,
                          input bit ovr_en, input logic [3:0] v0, input int n1, input logic [3:0] v1,
                          input int n2, input logic [3:0] v2, input int abort_n);
      int eff;
      int lat;
      int low_cnt;
      logic [KW-1:0] exp;
      eff     = (off == 4'd0) ? 1 : int'(off);
      lat     = -1;
      low_cnt = 0;
      exp_q.push_back(exp_key);
      @(negedge clk);
      ovr              = ovr_en;
      man              = v0;
      sel_offset       = off;
      key_if.key_ready = (ready_delay == 0);
      start            = 1'b1;
      for (int n = 1; n <= KEY_LAT + 40; n++) begin
         @(negedge clk);
         if (n == 1) begin
            start = 1'b0;
            chk("key_cleared_on_start", 32'(key_if.key_out), 32'd0);
         end
         if (ovr_en && n == n1) man = v1;
         if (ovr_en && n == n2) man = v2;
         if (n == abort_n) begin
            reset_n = 1'b0;
            @(negedge clk);
            chk_reset_vals("abort");
            reset_n = 1'b1;
            exp_q.delete();
            ovr = 1'b0;
            return;
         end
         if ((n - 1) % PER == 0 && (n - 1) / PER < NC) begin
            chk("settle_sel0", 32'(sel0), 32'(((n - 1) / PER) & 15));
            chk("settle_sel1", 32'(sel1), 32'((((n - 1) / PER) + eff) & 15));
            chk("settle_busy", 32'(busy), 32'd1);
            chk("settle_puf_reset", 32'(puf_reset), 32'd1);
         end
         if ((n - 1) % PER == SC && (n - 1) / PER < NC)
            chk("eval_puf_reset", 32'(puf_reset), 32'd0);
         if (!puf_reset) low_cnt++;
         if (key_if.key_valid) begin
            lat = n;
            break;
         end
      end
      if (lat < 0) begin
         chk("key_valid_seen", 32'd0, 32'd1);
         exp_q.delete();
         ovr = 1'b0;
         return;
      end
      chk("key_valid_latency", 32'(lat), 32'(KEY_LAT));
      chk("puf_reset_low_cycles", 32'(low_cnt), 32'(NC * (EC + 1)));
      chk("done_busy", 32'(busy), 32'd0);
      chk("done_puf_reset", 32'(puf_reset), 32'd1);
      exp = exp_q.pop_front();
      chk("key_out", 32'(key_if.key_out), 32'(exp));
      for (int i = 0; i < ready_delay; i++) begin
         @(negedge clk);
         chk("bp_key_valid", 32'(key_if.key_valid), 32'd1);
         chk("bp_key_out", 32'(key_if.key_out), 32'(exp));
         chk("bp_busy", 32'(busy), 32'd0);
         start = i[0];
      end
      // Handshake cycle, with a start that must be ignored.
      key_if.key_ready = 1'b1;
      start            = 1'b1;
      @(negedge clk);
      start            = 1'b0;
      key_if.key_ready = 1'b0;
      chk("hs_key_valid_low", 32'(key_if.key_valid), 32'd0);
      chk("hs_busy", 32'(busy), 32'd0);
      chk("hs_state_idle", 32'(dbg_state), 32'd0);
      chk("hs_key_out_held", 32'(key_if.key_out), 32'(exp));
      ovr = 1'b0;
   endtask

   initial begin
      vecs[0] = '{off: 4'd3,  ready_delay: 0,  exp_key: 16'h5753};
      vecs[1] = '{off: 4'd0,  ready_delay: 0,  exp_key: 16'h7131};
      vecs[2] = '{off: 4'd15, ready_delay: 20, exp_key: 16'h131F};
      vecs[3] = '{off: 4'd8,  ready_delay: 3,  exp_key: 16'h8888};

      reset_n          = 1'b0;
      start            = 1'b1;
      sel_offset       = 4'd0;
      key_if.key_ready = 1'b0;
      ovr              = 1'b0;
      man              = 4'd0;
      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      reset_n = 1'b1;
      start   = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 4; i++)
         run_key(vecs[i].off, vecs[i].ready_delay, vecs[i].exp_key, 1'b0, 4'd0, 0, 4'd0, 0, 4'd0, 0);

      // Response window: late change keeps old nibble, earlier change is captured.
      run_key(4'd3, 0, 16'hEEE9, 1'b1, 4'h9, 10, 4'h6, 19, 4'hE, 0);

      // Abort in EVAL of challenge 2, then a clean key.
      run_key(4'd3, 0, 16'h5753, 1'b0, 4'd0, 0, 4'd0, 0, 4'd0, 1 + 2 * PER + SC + 3);
      run_key(4'd3, 0, 16'h5753, 1'b0, 4'd0, 0, 4'd0, 0, 4'd0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
